// File: rtl/pdm_seq_pkg.sv
// Shared types and constants for the PDM sample sequencer.
package pdm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } seq_state_e;

  localparam int unsigned UNDERRUN_CNT_W = 16;

  // Offset-binary zero level for a sample of the given width.
  function automatic int unsigned mid_value(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pdm_seq_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally so a
// pop can consume it in the same cycle.
module pdm_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pdm_sample_sequencer.sv
// Paces buffered samples into the modulator once per period, ramping to/from
// mid-scale on start/stop. Define PDM_SEQ_UNDERRUN_CNT_EN for underrun_count.
module pdm_sample_sequencer
  import pdm_seq_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int RAMP_STEP   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [DIV_WIDTH-1:0]   period,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [INPUT_WIDTH-1:0] s_data,
  output logic [INPUT_WIDTH-1:0] sample,
  output logic                   sample_strobe,
  output logic                   busy,
  output logic                   underrun
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [INPUT_WIDTH:0] MID_EXT  = (INPUT_WIDTH+1)'(mid_value(INPUT_WIDTH));
  localparam logic [INPUT_WIDTH:0] STEP_EXT = (INPUT_WIDTH+1)'(RAMP_STEP);

  seq_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   period_q, period_d;
  logic [INPUT_WIDTH-1:0] sample_q, sample_d;
  logic                   strobe_q, strobe_d;
  logic                   underrun_q, underrun_d;
  logic                   tick;

  logic                   fifo_push, fifo_pop, fifo_flush;
  logic                   fifo_full, fifo_empty;
  logic [INPUT_WIDTH-1:0] fifo_head;
  logic [CW-1:0]          fifo_count;

  logic [INPUT_WIDTH:0]   sample_ext, up_sum, up_val, dn_val;

  pdm_seq_fifo #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign busy      = (state_q != IDLE);
  assign s_ready   = ((state_q == RAMP_UP) || (state_q == RUN)) && !fifo_full;
  assign fifo_push = s_valid && s_ready;

  // Period is latched at reload so a mid-count change never truncates a period.
  assign tick = busy && (cnt_q == period_q);

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    period_d = period_q;
    if (!busy || tick) begin
      cnt_d    = '0;
      period_d = period;
    end
  end

  // Ramps use one extra bit so the clamp sees the true sum/difference.
  assign sample_ext = {1'b0, sample_q};
  assign up_sum     = sample_ext + STEP_EXT;
  assign up_val     = (up_sum > MID_EXT) ? MID_EXT : up_sum;
  assign dn_val     = (sample_ext > STEP_EXT) ? (sample_ext - STEP_EXT) : '0;

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_flush = 1'b1;
        sample_d   = '0;
        if (enable) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
        end else if (tick) begin
          sample_d = up_val[INPUT_WIDTH-1:0];
          strobe_d = 1'b1;
          if (up_val == MID_EXT) state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
        end else if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sample_d = fifo_head;
            strobe_d = 1'b1;
          end else begin
            underrun_d = (fifo_count == '0);
          end
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          sample_d = dn_val[INPUT_WIDTH-1:0];
          strobe_d = 1'b1;
          if (dn_val == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      sample_q   <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      sample_q   <= sample_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample        = sample_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

`ifdef PDM_SEQ_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ur_cnt_q, ur_cnt_d;

  always_comb begin
    ur_cnt_d = ur_cnt_q;
    if (underrun_d && (ur_cnt_q != '1)) ur_cnt_d = ur_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ur_cnt_q <= '0;
    else          ur_cnt_q <= ur_cnt_d;
  end

  assign underrun_count = ur_cnt_q;
`endif

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// Scoreboard bench: stimulus queues expected strobe/underrun events, a negedge
// monitor pops and compares them as the sequencer produces them.
module tb_pdm_sample_sequencer;

  typedef struct packed {
    logic       is_ur;
    logic [7:0] val;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] period;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [7:0]  sample;
  logic        sample_strobe;
  logic        busy;
  logic        underrun;
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  pdm_sample_sequencer #(
    .INPUT_WIDTH (8),
    .DIV_WIDTH   (16),
    .FIFO_DEPTH  (4),
    .RAMP_STEP   (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .period        (period),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .sample        (sample),
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .underrun      (underrun)
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic exp_val(input logic [7:0] v);
    exp_q.push_back('{1'b0, v});
  endtask

  task automatic exp_ur();
    exp_q.push_back('{1'b1, 8'h00});
  endtask

  // Called at a negedge; returns one negedge after the transfer edge.
  task automatic push_word(input logic [7:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(s_ready), 32'd1);
    if (s_ready) exp_val(d);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Monitor: every strobe or underrun pulse must match the queue head.
  always @(negedge clk) begin
    if (reset_n && (sample_strobe || underrun)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: strobe=%0b underrun=%0b sample=0x%02h, required no event",
                 sample_strobe, underrun, sample);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_ur ? (underrun && !sample_strobe)
                        : (sample_strobe && !underrun && sample == mon_e.val)) begin
          $display("txn t=%0t strobe=%0b underrun=%0b sample=0x%02h ok",
                   $time, sample_strobe, underrun, sample);
        end else begin
          errors++;
          $display("FAIL scoreboard: got strobe=%0b underrun=%0b sample=0x%02h, required %s sample=0x%02h",
                   sample_strobe, underrun, sample, mon_e.is_ur ? "underrun" : "strobe", mon_e.val);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    period  = 16'd3;
    s_valid = 1'b0;
    s_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    chk("rst_ur_count", 32'(underrun_count), 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // Start-up ramp: 32, 64, 96, 128, one tick per 4 cycles
    enable = 1'b1;
    exp_val(8'd32); exp_val(8'd64); exp_val(8'd96); exp_val(8'd128);
    @(negedge clk);
    chk("startup_busy", 32'(busy), 32'd1);
    chk("startup_ready", 32'(s_ready), 32'd1);
    repeat (16) @(negedge clk);
    chk("startup_last_sample", 32'(sample), 32'd128);
    chk("startup_last_strobe", 32'(sample_strobe), 32'd1);

    // Streaming three words in RUN
    push_word(8'h10);
    push_word(8'h20);
    push_word(8'h30);
    repeat (9) @(negedge clk);
    #1;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Underrun on the next tick; longer period takes effect at that reload
    period = 16'd15;
    exp_ur();
    repeat (4) @(negedge clk);
    #1;
    chk("underrun_drained", 32'(exp_q.size()), 32'd0);
    chk("underrun_hold", 32'(sample), 32'h30);
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    chk("underrun_count_1", 32'(underrun_count), 32'd1);
`endif

    // Backpressure: 4 transfers, then ready only right after the pop
    s_valid = 1'b1;
    s_data  = 8'hA0;
    for (int k = 0; k < 18; k++) begin
      logic xfer;
      xfer = s_ready;
      chk($sformatf("bp_ready_k%0d", k), 32'(s_ready), ((k < 4) || (k == 16)) ? 32'd1 : 32'd0);
      if (xfer && s_data == 8'hA0) exp_val(8'hA0);
      @(negedge clk);
      if (xfer) s_data = s_data + 8'd1;
    end
    s_valid = 1'b0;

    // Stop from RUN: buffered words are discarded, ramp 160 -> 0
    enable = 1'b0;
    period = 16'd3;
    exp_val(8'd128); exp_val(8'd96); exp_val(8'd64); exp_val(8'd32); exp_val(8'd0);
    repeat (30) @(negedge clk);
    #1;
    chk("stop_drained", 32'(exp_q.size()), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_sample", 32'(sample), 32'd0);
    chk("stop_s_ready", 32'(s_ready), 32'd0);

    // Restart: flushed FIFO means the first RUN tick underruns
    enable = 1'b1;
    exp_val(8'd32); exp_val(8'd64); exp_val(8'd96); exp_val(8'd128);
    exp_ur();
    repeat (21) @(negedge clk);
    #1;
    chk("flush_drained", 32'(exp_q.size()), 32'd0);
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    chk("underrun_count_2", 32'(underrun_count), 32'd2);
`endif
    enable = 1'b0;
    exp_val(8'd96); exp_val(8'd64); exp_val(8'd32); exp_val(8'd0);
    repeat (16) @(negedge clk);
    #1;
    chk("rundown_drained", 32'(exp_q.size()), 32'd0);
    chk("rundown_busy", 32'(busy), 32'd0);

    // Stop mid-ramp at 64: 32 then 0
    enable = 1'b1;
    exp_val(8'd32); exp_val(8'd64); exp_val(8'd32); exp_val(8'd0);
    repeat (9) @(negedge clk);
    #1;
    chk("midramp_at64", 32'(sample), 32'd64);
    chk("midramp_pending", 32'(exp_q.size()), 32'd2);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("midramp_32_busy", 32'(busy), 32'd1);
    chk("midramp_32", 32'(sample), 32'd32);
    repeat (4) @(negedge clk);
    #1;
    chk("midramp_drained", 32'(exp_q.size()), 32'd0);
    chk("midramp_idle", 32'(busy), 32'd0);
    chk("midramp_ready", 32'(s_ready), 32'd0);

    // Async reset mid-RUN
    enable = 1'b1;
    exp_val(8'd32); exp_val(8'd64); exp_val(8'd96); exp_val(8'd128);
    @(negedge clk);
    push_word(8'h55);
    repeat (19) @(negedge clk);
    #1;
    chk("pre_reset_drained", 32'(exp_q.size()), 32'd0);
    chk("pre_reset_sample", 32'(sample), 32'h55);
    chk("pre_reset_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_sample", 32'(sample), 32'd0);
    chk("async_s_ready", 32'(s_ready), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_strobe", 32'(sample_strobe), 32'd0);
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    chk("async_ur_count", 32'(underrun_count), 32'd0);
`endif
    enable = 1'b0;
    #20;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
